crp16_clock_ctrl: RTL and testbench

//   Processor clock generator that sits directly upstream of the CRP16 processor/datapath clock input.

---
 rtl/crp16_clock_ctrl_if.sv | 25 ++
 rtl/crp16_clock_ctrl.sv | 156 +++++++++++++++
 tb/tb_crp16_clock_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/crp16_clock_ctrl_if.sv
// crp16_clock_ctrl_if: control/status bundle of the CRP16 clock controller; breakpoint signals exist only with CRP16_CLKCTRL_BREAK_EN
interface crp16_clock_ctrl_if;
   logic        run_mode;
   logic        step_n;
   logic [1:0]  speed_sel;
   logic        cpu_clock;
   logic        cpu_rise;
   logic        busy;
   logic [15:0] cycle_count;
`ifdef CRP16_CLKCTRL_BREAK_EN
   logic [15:0] pc;
   logic [15:0] break_addr;
   logic        break_on;
   logic        halted;
   modport master (output run_mode, step_n, speed_sel, pc, break_addr, break_on,
                   input  cpu_clock, cpu_rise, busy, cycle_count, halted);
   modport slave  (input  run_mode, step_n, speed_sel, pc, break_addr, break_on,
                   output cpu_clock, cpu_rise, busy, cycle_count, halted);
`else
   modport master (output run_mode, step_n, speed_sel,
                   input  cpu_clock, cpu_rise, busy, cycle_count);
   modport slave  (input  run_mode, step_n, speed_sel,
                   output cpu_clock, cpu_rise, busy, cycle_count);
`endif
endinterface

// File: rtl/crp16_clock_ctrl.sv
// crp16_clock_ctrl: CRP16 cpu_clock generator (free-run divider or debounced single-step); CRP16_CLKCTRL_BREAK_EN adds PC breakpoint halt
module crp16_clock_ctrl #(
   parameter int DIV_WIDTH       = 24,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int STEP_HALF       = 25000
) (
   input logic               clock,
   input logic               reset,
   crp16_clock_ctrl_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(STEP_HALF + 1);
   localparam int TW = $clog2(DIV_WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, STEP_HI, STEP_LO} state_t;
   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q, key_q, key_d, press_q, press_d;
   logic [DW-1:0]        deb_q, deb_d;
   logic [DIV_WIDTH-1:0] div_q, div_d, div_inc;
   logic [HW-1:0]        half_q, half_d;
   logic [TW-1:0]        tap_idx;
   logic                 cpu_clock_q, cpu_clock_d, cpu_rise_q, cpu_rise_d, busy_q, busy_d;
   logic [15:0]          count_q, count_d;
   logic                 tap_nxt, run_go, stop;
`ifdef CRP16_CLKCTRL_BREAK_EN
   logic                 halted_q, halted_d, brk_q, brk_d, run_prev_q, brk_hit;
   assign bus.halted = halted_q;
`endif
   assign tap_idx         = TW'(DIV_WIDTH - 1) - TW'(bus.speed_sel);
   assign bus.cpu_clock   = cpu_clock_q;
   assign bus.cpu_rise    = cpu_rise_q;
   assign bus.busy        = busy_q;
   assign bus.cycle_count = count_q;

   // accept a new key level only after DEBOUNCE_CYCLES consecutive differing samples; press = accepted 1->0
   always_comb begin
      key_d   = key_q;
      deb_d   = '0;
      if (sync2_q != key_q) begin
         deb_d = deb_q + 1'b1;
         if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            key_d = sync2_q;
            deb_d = '0;
         end
      end
      press_d = key_q & ~key_d;
   end

   // button synchroniser and debounce state; key idles released (1)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         key_q   <= 1'b1;
         deb_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= bus.step_n;
         sync2_q <= sync1_q;
         key_q   <= key_d;
         deb_q   <= deb_d;
         press_q <= press_d;
      end
   end

   // clock FSM next state: divider tap in RUN, half-period timing in single-step
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      half_d      = half_q;
      cpu_clock_d = cpu_clock_q;
      div_inc     = div_q + 1'b1;
      tap_nxt     = div_inc[tap_idx];
`ifdef CRP16_CLKCTRL_BREAK_EN
      brk_hit     = brk_q | (bus.break_on & cpu_rise_q & (bus.pc == bus.break_addr));
      brk_d       = 1'b0;
      halted_d    = halted_q;
      run_go      = halted_q ? bus.run_mode & ~run_prev_q : bus.run_mode;
      stop        = ~bus.run_mode | brk_hit;
`else
      run_go      = bus.run_mode;
      stop        = ~bus.run_mode;
`endif
      case (state_q)
         IDLE: begin
            cpu_clock_d = 1'b0;
            if (run_go) begin
               state_d = RUN;
               div_d   = '0;
            end else if (press_q) begin
               state_d     = STEP_HI;
               half_d      = HW'(STEP_HALF - 1);
               cpu_clock_d = 1'b1;
            end
         end
         RUN: begin
            div_d       = div_inc;
            cpu_clock_d = tap_nxt;
            if (stop & cpu_clock_q & ~tap_nxt) state_d = IDLE;
         end
         STEP_HI: begin
            half_d = half_q - 1'b1;
            if (half_q == '0) begin
               state_d     = STEP_LO;
               half_d      = HW'(STEP_HALF - 1);
               cpu_clock_d = 1'b0;
            end
         end
         STEP_LO: begin
            half_d = half_q - 1'b1;
            if (half_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef CRP16_CLKCTRL_BREAK_EN
      if (state_q == RUN) begin
         brk_d = brk_hit & (state_d == RUN);
         if (state_d == IDLE) halted_d = brk_hit;
      end
      if (state_q == IDLE && state_d != IDLE) halted_d = 1'b0;
`endif
      cpu_rise_d = cpu_clock_d & ~cpu_clock_q;
      count_d    = count_q + {15'd0, cpu_rise_d};
      busy_d     = state_d != IDLE;
   end

   // FSM state and registered outputs; reset drops cpu_clock immediately
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         div_q       <= '0;
         half_q      <= '0;
         cpu_clock_q <= 1'b0;
         cpu_rise_q  <= 1'b0;
         busy_q      <= 1'b0;
         count_q     <= '0;
`ifdef CRP16_CLKCTRL_BREAK_EN
         halted_q    <= 1'b0;
         brk_q       <= 1'b0;
         run_prev_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         half_q      <= half_d;
         cpu_clock_q <= cpu_clock_d;
         cpu_rise_q  <= cpu_rise_d;
         busy_q      <= busy_d;
         count_q     <= count_d;
`ifdef CRP16_CLKCTRL_BREAK_EN
         halted_q    <= halted_d;
         brk_q       <= brk_d;
         run_prev_q  <= bus.run_mode;
`endif
      end
   end
endmodule

// File: tb/tb_crp16_clock_ctrl.sv
// tb_crp16_clock_ctrl: directed bench for crp16_clock_ctrl (DIV_WIDTH=4, DEBOUNCE_CYCLES=4, STEP_HALF=2)
module tb_crp16_clock_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   compared = 0;
   int   mismatched = 0;

   crp16_clock_ctrl_if bus();

   crp16_clock_ctrl #(.DIV_WIDTH(4), .DEBOUNCE_CYCLES(4), .STEP_HALF(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      repeat (3) @(negedge clock);
      compared++; if (bus.cpu_clock !== 1'b0) begin mismatched++; $display("FAIL reset_clk got %b exp 0", bus.cpu_clock); end
      compared++; if (bus.cpu_rise !== 1'b0) begin mismatched++; $display("FAIL reset_rise got %b exp 0", bus.cpu_rise); end
      compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      compared++; if (bus.cycle_count !== 16'h0000) begin mismatched++; $display("FAIL reset_count got %h exp 0000", bus.cycle_count); end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL post_reset_busy got %b exp 0", bus.busy); end
   endtask

   // free-run at speed_sel=0 (period 16), a dropped press during RUN, stop while high
   task automatic test_run;
      logic        e_clk, e_rise;
      logic [15:0] e_cnt;
      bus.run_mode = 1'b1;
      for (int k = 1; k <= 76; k++) begin
         @(negedge clock);
         e_clk  = ((k - 1) % 16) >= 8;
         e_rise = ((k - 1) % 16) == 8;
         e_cnt  = 16'((k + 7) / 16);
         compared++; if (bus.cpu_clock !== e_clk) begin mismatched++; $display("FAIL run_clk k=%0d got %b exp %b", k, bus.cpu_clock, e_clk); end
         compared++; if (bus.cpu_rise !== e_rise) begin mismatched++; $display("FAIL run_rise k=%0d got %b exp %b", k, bus.cpu_rise, e_rise); end
         compared++; if (bus.cycle_count !== e_cnt) begin mismatched++; $display("FAIL run_count k=%0d got %0d exp %0d", k, bus.cycle_count, e_cnt); end
         compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL run_busy k=%0d got %b exp 1", k, bus.busy); end
         bus.step_n = !(k >= 60 && k < 66);
         if (k == 76) bus.run_mode = 1'b0;
      end
      for (int k = 77; k <= 88; k++) begin
         @(negedge clock);
         e_clk = k <= 80;
         compared++; if (bus.cpu_clock !== e_clk) begin mismatched++; $display("FAIL stop_clk k=%0d got %b exp %b", k, bus.cpu_clock, e_clk); end
         compared++; if (bus.busy !== e_clk) begin mismatched++; $display("FAIL stop_busy k=%0d got %b exp %b", k, bus.busy, e_clk); end
         compared++; if (bus.cycle_count !== 16'd5) begin mismatched++; $display("FAIL stop_count k=%0d got %0d exp 5", k, bus.cycle_count); end
      end
   endtask

   // one debounced press gives one 2-high/2-low pulse, 7 cycles after the press
   task automatic test_step;
      logic [14:1] e_clk_v  = 14'b00000011000000;
      logic [14:1] e_busy_v = 14'b00001111000000;
      logic [14:1] e_rise_v = 14'b00000001000000;
      logic [15:0] e_cnt;
      bus.step_n = 1'b0;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clock);
         e_cnt = (j < 7) ? 16'd5 : 16'd6;
         compared++; if (bus.cpu_clock !== e_clk_v[j]) begin mismatched++; $display("FAIL step_clk j=%0d got %b exp %b", j, bus.cpu_clock, e_clk_v[j]); end
         compared++; if (bus.busy !== e_busy_v[j]) begin mismatched++; $display("FAIL step_busy j=%0d got %b exp %b", j, bus.busy, e_busy_v[j]); end
         compared++; if (bus.cpu_rise !== e_rise_v[j]) begin mismatched++; $display("FAIL step_rise j=%0d got %b exp %b", j, bus.cpu_rise, e_rise_v[j]); end
         compared++; if (bus.cycle_count !== e_cnt) begin mismatched++; $display("FAIL step_count j=%0d got %0d exp %0d", j, bus.cycle_count, e_cnt); end
         if (j == 10) bus.step_n = 1'b1;
      end
      repeat (6) @(negedge clock);
   endtask

   // bouncing button (2-cycle toggles) never reaches the debounce count
   task automatic test_bounce;
      for (int i = 0; i < 28; i++) begin
         bus.step_n = (i < 20 && (i % 4) < 2) ? 1'b0 : 1'b1;
         @(negedge clock);
         compared++; if (bus.cpu_clock !== 1'b0) begin mismatched++; $display("FAIL bounce_clk i=%0d got %b exp 0", i, bus.cpu_clock); end
         compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL bounce_busy i=%0d got %b exp 0", i, bus.busy); end
      end
      compared++; if (bus.cycle_count !== 16'd6) begin mismatched++; $display("FAIL bounce_count got %0d exp 6", bus.cycle_count); end
   endtask

   // speed_sel=2 gives period 4; stop requested in the high phase
   task automatic test_speed;
      logic        e_clk;
      logic [15:0] e_cnt;
      bus.speed_sel = 2'd2;
      bus.run_mode  = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clock);
         e_clk = (k <= 12) ? 1'((k - 1) >> 1) : 1'b0;
         e_cnt = 16'(6 + (k >= 3) + (k >= 7) + (k >= 11));
         compared++; if (bus.cpu_clock !== e_clk) begin mismatched++; $display("FAIL speed_clk k=%0d got %b exp %b", k, bus.cpu_clock, e_clk); end
         compared++; if (bus.busy !== (k <= 12)) begin mismatched++; $display("FAIL speed_busy k=%0d got %b exp %b", k, bus.busy, k <= 12); end
         compared++; if (bus.cycle_count !== e_cnt) begin mismatched++; $display("FAIL speed_count k=%0d got %0d exp %0d", k, bus.cycle_count, e_cnt); end
         if (k == 11) bus.run_mode = 1'b0;
      end
      bus.speed_sel = 2'd0;
   endtask

   // async reset in STEP_HI clears cpu_clock and count before the next edge
   task automatic test_reset_mid;
      bus.step_n = 1'b0;
      repeat (7) @(negedge clock);
      compared++; if (bus.cpu_clock !== 1'b1) begin mismatched++; $display("FAIL mid_pre_clk got %b exp 1", bus.cpu_clock); end
      compared++; if (bus.cycle_count !== 16'd10) begin mismatched++; $display("FAIL mid_pre_count got %0d exp 10", bus.cycle_count); end
      #2 reset = 1'b1;
      #1;
      compared++; if (bus.cpu_clock !== 1'b0) begin mismatched++; $display("FAIL mid_clk got %b exp 0", bus.cpu_clock); end
      compared++; if (bus.cycle_count !== 16'd0) begin mismatched++; $display("FAIL mid_count got %0d exp 0", bus.cycle_count); end
      compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
      bus.step_n = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (8) @(negedge clock);
      compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL mid_after_busy got %b exp 0", bus.busy); end
      compared++; if (bus.cpu_clock !== 1'b0) begin mismatched++; $display("FAIL mid_after_clk got %b exp 0", bus.cpu_clock); end
   endtask

`ifdef CRP16_CLKCTRL_BREAK_EN
   task automatic test_break;
      int   rises = 0;
      logic done = 1'b0;
      bus.pc         = 16'h0000;
      bus.break_addr = 16'h0003;
      bus.break_on   = 1'b1;
      bus.speed_sel  = 2'd2;
      bus.run_mode   = 1'b1;
      for (int i = 0; i < 80 && !done; i++) begin
         @(negedge clock);
         if (bus.cpu_rise) begin
            rises++;
            bus.pc = 16'(rises);
         end
         done = bus.halted;
      end
      compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL brk_halted got %b exp 1", done); end
      compared++; if (rises != 3) begin mismatched++; $display("FAIL brk_rises got %0d exp 3", rises); end
      compared++; if (bus.cycle_count !== 16'd3) begin mismatched++; $display("FAIL brk_count got %0d exp 3", bus.cycle_count); end
      compared++; if (bus.cpu_clock !== 1'b0) begin mismatched++; $display("FAIL brk_clk got %b exp 0", bus.cpu_clock); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         compared++; if (bus.cpu_rise !== 1'b0) begin mismatched++; $display("FAIL brk_hold_rise i=%0d got %b exp 0", i, bus.cpu_rise); end
      end
      compared++; if (bus.halted !== 1'b1) begin mismatched++; $display("FAIL brk_hold_halted got %b exp 1", bus.halted); end
      bus.run_mode = 1'b0;
      @(negedge clock);
      bus.run_mode = 1'b1;
      @(negedge clock);
      compared++; if (bus.halted !== 1'b0) begin mismatched++; $display("FAIL brk_resume_halted got %b exp 0", bus.halted); end
      compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL brk_resume_busy got %b exp 1", bus.busy); end
      bus.break_on = 1'b0;
      bus.run_mode = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 32 && !done; i++) begin
         @(negedge clock);
         done = !bus.busy;
      end
      compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL brk_stop_timeout busy still %b", bus.busy); end
   endtask
`endif

   initial begin
      bus.run_mode  = 1'b0;
      bus.step_n    = 1'b1;
      bus.speed_sel = 2'd0;
`ifdef CRP16_CLKCTRL_BREAK_EN
      bus.pc         = 16'h0000;
      bus.break_addr = 16'h0000;
      bus.break_on   = 1'b0;
`endif
      test_reset;
      test_run;
      test_step;
      test_bounce;
      test_speed;
      test_reset_mid;
`ifdef CRP16_CLKCTRL_BREAK_EN
      test_break;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
